execute_hilo_unit: RTL
======================

Name: execute_hilo_unit

Overview:
- Multi-cycle multiply/divide unit in the Execute stage. It consumes the decoded operation and operands latched by the Decode-to-Execute pipeline register.
- Owns the architectural HI/LO registers and runs MIPS MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU/MTHI/MTLO.
- Asserts Busy so hazard logic can stall Decode and Execute while an operation is in flight. MFHI/MFLO read HI/LO directly.

Parameters:
- DIV_ITERS, 32, number of restoring-division iterations. Equals operand width. Fixed at 32 for this design.

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  launch the operation in Op this cycle
- Op  in  4  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO; 10-15 no-op
- ReadData1  in  32  rs operand (dividend / multiplicand / MT source)
- ReadData2  in  32  rt operand (divisor / multiplier)
- Flush  in  1  abort any in-progress operation
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  state != IDLE (registered)
- Done  out  1  one-cycle pulse after a MUL/DIV result is written
- DivZero  out  1  one-cycle pulse on DIV/DIVU with ReadData2 == 0

Behaviour:
- Reset: HI=0, LO=0, state IDLE, Busy=0, Done=0, DivZero=0. Reset overrides Start and Flush and aborts any operation mid-flight.
- States are IDLE, MUL, DIV, DIVFIX. Start is sampled only in IDLE. Start while Busy is ignored, because upstream stall guarantees it never occurs.
- Flush in the same cycle as Start: Start ignored. Flush in MUL/DIV/DIVFIX: go to IDLE, HI/LO unchanged, no Done.
- MTHI/MTLO (Start in cycle t): HI or LO = ReadData1 at edge ending t. No Busy, no Done.
- MUL path, Start in cycle t:
  - Edge ending t latches the 64-bit product. Signed for MULT/MADD/MSUB; unsigned for the U variants.
  - State is MUL in cycle t+1, Busy=1.
  - Edge ending t+1 writes {HI,LO} = product (MULT/U), {HI,LO}+product (MADD/U), or {HI,LO}-product (MSUB/U). Arithmetic is modulo 2^64.
  - Done=1 in cycle t+2.
- DIV path, Start in cycle t, divisor != 0:
  - Edge ending t latches magnitudes. Signed: abs of two's complement, so |0x80000000| = 0x80000000 unsigned. DIVU uses raw values.
  - Also latches quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign); both are zero for DIVU.
  - Iteration counter is cleared.
  - Cycles t+1..t+32 are state DIV. Each edge performs one restoring step: shift remainder:dividend left by 1, trial-subtract divisor, set quotient bit when non-negative.
  - Counter 31 -> DIVFIX. Cycle t+33 is DIVFIX.
  - Edge ending t+33 writes LO = signed-corrected quotient and HI = signed-corrected remainder, then returns to IDLE.
  - Done=1 in cycle t+34. Busy=1 in cycles t+1..t+33.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
- DIV/DIVU with ReadData2 == 0: state stays IDLE, HI/LO unchanged, DivZero=1 and Done=1 in cycle t+1. Busy is never asserted.
- Op 10-15 with Start: no effect.
- Done and DivZero are registered and high for exactly one cycle; otherwise 0.
- HI/LO outputs always reflect the registers. During Busy they hold the old values, and the consumer must stall.

Optional Feature:
- Macro HILO_MADD_EN.
  - Defined: Ops 2-5 (MADD/MADDU/MSUB/MSUBU) accumulate into {HI,LO} as above.
  - Undefined: Ops 2-5 are treated as no-ops. No Busy, no Done, HI/LO unchanged, and no accumulate adder/subtractor is synthesised.

Test Plan:
- MULT ReadData1=0xFFFFFFFD (-3), ReadData2=7 -> Busy for 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulse 2 cycles after Start.
- MULTU 0xFFFFFFFF * 2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> Busy for 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; Done in cycle t+34. DIVU of the same operands -> LO=0x7FFFFFFC, HI=1.
- DIV 10 / 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> DivZero and Done pulse in cycle t+1; HI/LO unchanged; Busy never high.
- DIV 100/3 with Flush asserted in cycle t+10 -> IDLE in cycle t+11; no Done; HI/LO keep prior values. A subsequent MULT 4*5 -> LO=20.
- (HILO_MADD_EN) MTLO 5, MTHI 0, then MADD 3*4 -> LO=17, HI=0; then MSUB 5*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF8. Without the macro, LO stays 5.

Source files
------------

// File: rtl/execute_hilo_unit.sv
// Execute-stage multiply/divide unit that owns the HI/LO registers. Multiplies take
// one extra cycle; divides run a restoring loop of DIV_ITERS steps followed by a sign fixup.
// Optional macro HILO_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module execute_hilo_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        Flush,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);
  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

  localparam logic [3:0] OP_MULT  = 4'd0, OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd6, OP_DIVU  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8, OP_MTLO  = 4'd9;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd2, OP_MADDU = 4'd3;
  localparam logic [3:0] OP_MSUB  = 4'd4, OP_MSUBU = 4'd5;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_e;
  acc_e acc_q, acc_d;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIVFIX} state_e;
  state_e state_q, state_d;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d, rneg_q, rneg_d;
  logic          done_q, done_d, dz_q, dz_d;

  // Ops 0..5 are signed when Op[0] is clear; zero-extension covers the U variants.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, mul_prod;
  assign mul_sgn  = ~Op[0];
  assign mul_a    = {{32{mul_sgn & ReadData1[31]}}, ReadData1};
  assign mul_b    = {{32{mul_sgn & ReadData2[31]}}, ReadData2};
  assign mul_prod = mul_a * mul_b;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = (Op == OP_DIV) & ReadData1[31];
  assign b_neg = (Op == OP_DIV) & ReadData2[31];
  assign a_mag = a_neg ? (~ReadData1 + 32'd1) : ReadData1;
  assign b_mag = b_neg ? (~ReadData2 + 32'd1) : ReadData2;

  // Restoring step: quo_q doubles as the dividend shift register and the quotient.
  logic [32:0] shifted, trial;
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef HILO_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: if (Start && !Flush) begin
        case (Op)
          OP_MULT, OP_MULTU: begin
            prod_d  = mul_prod;
            state_d = S_MUL;
`ifdef HILO_MADD_EN
            acc_d   = ACC_SET;
          end
          OP_MADD, OP_MADDU: begin
            prod_d  = mul_prod;
            acc_d   = ACC_ADD;
            state_d = S_MUL;
          end
          OP_MSUB, OP_MSUBU: begin
            prod_d  = mul_prod;
            acc_d   = ACC_SUB;
            state_d = S_MUL;
`endif
          end
          OP_DIV, OP_DIVU: begin
            if (ReadData2 == 32'd0) begin
              done_d = 1'b1;
              dz_d   = 1'b1;
            end else begin
              rem_d   = 32'd0;
              quo_d   = a_mag;
              dvs_d   = b_mag;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = '0;
              state_d = S_DIV;
            end
          end
          OP_MTHI: hi_d = ReadData1;
          OP_MTLO: lo_d = ReadData1;
          default: ;
        endcase
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!Flush) begin
          done_d = 1'b1;
`ifdef HILO_MADD_EN
          case (acc_q)
            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
            default: {hi_d, lo_d} = prod_q;
          endcase
`else
          {hi_d, lo_d} = prod_q;
`endif
        end
      end
      S_DIV: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = trial[32] ? shifted[31:0] : trial[31:0];
          quo_d = {quo_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DIVFIX;
        end
      end
      S_DIVFIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          lo_d   = qneg_q ? (~quo_q + 32'd1) : quo_q;
          hi_d   = rneg_q ? (~rem_q + 32'd1) : rem_q;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q   <= ACC_SET;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef HILO_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DivZero = dz_q;
endmodule
